// File: rtl/ltc5548_sys_timer_seq.sv
// Avalon-MM master that walks the interval timer through a table of one-shot periods, one step pulse per expiry.
// Define TIMER_SEQ_VERIFY_EN to read back period_l/period_h after programming and abort (sticky err) on mismatch.
module ltc5548_sys_timer_seq #(
    parameter int NSTEPS = 8,
    parameter int IW     = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          loop_en,
    input  logic [IW:0]   num_steps,
    input  logic          tbl_we,
    input  logic [IW-1:0] tbl_addr,
    input  logic [31:0]   tbl_wdata,
    output logic [2:0]    m_address,
    output logic          m_chipselect,
    output logic          m_write_n,
    output logic [15:0]   m_writedata,
    input  logic [15:0]   m_readdata,
    input  logic          timer_irq,
    output logic          busy,
    output logic          step_pulse,
    output logic [IW-1:0] step_idx,
    output logic          done,
    output logic          err
);

    typedef enum logic [3:0] {
        IDLE, WR_STOP, WR_PL, WR_PH, RD_PL, RD_PH, RD_CHK,
        WR_CLR, WR_START, WAIT_IRQ, ACK, ABORT
    } state_t;

    localparam logic [2:0]  A_STATUS   = 3'd0;
    localparam logic [2:0]  A_CONTROL  = 3'd1;
    localparam logic [2:0]  A_PERIODL  = 3'd2;
    localparam logic [2:0]  A_PERIODH  = 3'd3;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;
    localparam logic [15:0] CTRL_START = 16'h0005;
    localparam logic [IW:0] NS_MAX     = (IW+1)'(NSTEPS);

    logic [31:0] tbl_q [NSTEPS];

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   ent_q, ent_d;
    logic [2:0]    addr_q, addr_d;
    logic [15:0]   wdat_q, wdat_d;
    logic          cs_q, cs_d;
    logic          wn_q, wn_d;
    logic          pulse_q, pulse_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic          num_ok;
    logic [IW:0]   nxt_w;

    assign num_ok = (num_steps != '0) && (num_steps <= NS_MAX);
    assign nxt_w  = {1'b0, idx_q} + (IW+1)'(1);

`ifdef TIMER_SEQ_VERIFY_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^m_readdata;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_q[tbl_addr] <= tbl_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ent_d   = ent_q;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        pulse_d = 1'b0;
        done_d  = 1'b0;
`ifdef TIMER_SEQ_VERIFY_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && num_ok) begin
                    state_d = WR_STOP;
                    idx_d   = '0;
                end
            end
            WR_STOP:  state_d = WR_PL;
            WR_PL:    state_d = WR_PH;
`ifdef TIMER_SEQ_VERIFY_EN
            WR_PH:    state_d = RD_PL;
            RD_PL:    state_d = RD_PH;
            // readdata trails the presented address by one cycle
            RD_PH: begin
                if (m_readdata != ent_q[15:0]) begin
                    err_d   = 1'b1;
                    state_d = ABORT;
                end else begin
                    state_d = RD_CHK;
                end
            end
            RD_CHK: begin
                if (m_readdata != ent_q[31:16]) begin
                    err_d   = 1'b1;
                    state_d = ABORT;
                end else begin
                    state_d = WR_CLR;
                end
            end
`else
            WR_PH:    state_d = WR_CLR;
`endif
            WR_CLR:   state_d = WR_START;
            WR_START: state_d = WAIT_IRQ;
            WAIT_IRQ: begin
                if (timer_irq) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if ((nxt_w < num_steps) && (nxt_w < NS_MAX)) begin
                    idx_d   = nxt_w[IW-1:0];
                    state_d = WR_PL;
                end else if (loop_en) begin
                    idx_d   = '0;
                    state_d = WR_PL;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            ABORT:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // abort beats irq and any pending done
        if (abort && (state_q != IDLE) && (state_q != ABORT)) begin
            state_d = ABORT;
            idx_d   = idx_q;
            done_d  = 1'b0;
        end

        if (state_d == WR_PL) begin
            ent_d = (tbl_q[idx_d] == 32'd0) ? 32'd1 : tbl_q[idx_d];
        end

        case (state_d)
            WR_STOP, ABORT: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CONTROL; wdat_d = CTRL_STOP;
            end
            WR_PL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PERIODL; wdat_d = ent_d[15:0];
            end
            WR_PH: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PERIODH; wdat_d = ent_d[31:16];
            end
            RD_PL: begin
                cs_d = 1'b1; addr_d = A_PERIODL;
            end
            RD_PH: begin
                cs_d = 1'b1; addr_d = A_PERIODH;
            end
            WR_CLR: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_STATUS; wdat_d = 16'h0000;
            end
            WR_START: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CONTROL; wdat_d = CTRL_START;
            end
            ACK: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_STATUS; wdat_d = 16'h0000;
                pulse_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ent_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef TIMER_SEQ_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ent_q   <= ent_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
`ifdef TIMER_SEQ_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_writedata  = wdat_q;
    assign busy         = busy_q;
    assign step_pulse   = pulse_q;
    assign step_idx     = idx_q;
    assign done         = done_q;

endmodule

// File: tb/tb_ltc5548_sys_timer_seq.sv
// Bench for ltc5548_sys_timer_seq: a timer model answers the bus, an event-list model predicts every cycle.
module tb_ltc5548_sys_timer_seq;
    localparam int NSTEPS = 8;
    localparam int IW     = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, loop_en = 1'b0, tbl_we = 1'b0;
    logic [IW:0]   num_steps = 1;
    logic [IW-1:0] tbl_addr = '0;
    logic [31:0]   tbl_wdata = '0;
    logic [2:0]    m_address;
    logic          m_chipselect, m_write_n;
    logic [15:0]   m_writedata;
    logic [15:0]   m_readdata = '0;
    logic          timer_irq = 1'b0;
    logic          busy, step_pulse, done, err;
    logic [IW-1:0] step_idx;

    always #5 clk = ~clk;

    ltc5548_sys_timer_seq #(.NSTEPS(NSTEPS), .IW(IW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .loop_en(loop_en),
        .num_steps(num_steps), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .timer_irq(timer_irq),
        .busy(busy), .step_pulse(step_pulse), .step_idx(step_idx), .done(done), .err(err)
    );

    int total = 0, bad = 0, cyc = 0;

    // expected activity: kind 0 plain access, 1 stop (load entry 0 after), 2 ack, 3 done, 4 readback abort
    typedef struct { int cyc; bit cs; bit wn; logic [2:0] a; logic [15:0] d; int kind; } ev_t;
    ev_t           evq[$];
    logic [31:0]   tbl_m [NSTEPS];
    int            m_state = 0;          // 0 idle, 1 running, 2 abort write cycle
    logic [IW-1:0] m_idx = '0;
    bit            exp_err = 0, first_now = 0, ack_now = 0, m_corrupt = 0;

    logic [15:0]   t_pl = '0, t_ph = '0, rd_val = '0;
    bit            t_armed = 0, rd_pend = 0, t_corrupt = 0;
    int            t_fire = 0;

    int            last_startw = 0, last_pulse = 0, last_done = 0;
    int            n_done = 0, n_stopw = 0, n_wr = 0, n_startw = 0;
    logic [15:0]   pl_hist[$], ph_hist[$];
    int            idx_hist[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    function automatic void push(int c, bit cs, bit wn, logic [2:0] a, logic [15:0] d, int kind);
        ev_t e;
        e.cyc = c; e.cs = cs; e.wn = wn; e.a = a; e.d = d; e.kind = kind;
        evq.push_back(e);
    endfunction

    // one table entry: program, (read back), clear, start, then ack period+2 cycles after the start write
    function automatic void gen_block(int t, logic [IW-1:0] idx);
        logic [31:0] v;
        int b;
        v = (tbl_m[idx] == 32'd0) ? 32'd1 : tbl_m[idx];
        push(t + 1, 1, 0, 3'd2, v[15:0], 0);
        push(t + 2, 1, 0, 3'd3, v[31:16], 0);
        b = t + 2;
`ifdef TIMER_SEQ_VERIFY_EN
        push(t + 3, 1, 1, 3'd2, 16'h0, 0);
        push(t + 4, 1, 1, 3'd3, 16'h0, 0);
        if (m_corrupt) begin
            m_corrupt = 0;
            push(t + 5, 1, 0, 3'd1, 16'h0008, 4);
            return;
        end
        b = t + 5;
`endif
        push(b + 1, 1, 0, 3'd0, 16'h0000, 0);
        push(b + 2, 1, 0, 3'd1, 16'h0005, 0);
        push(b + 2 + int'(v) + 2, 1, 0, 3'd0, 16'h0000, 2);
    endfunction

    task automatic model_eoc();
        logic [IW:0] nx;
        nx = {1'b0, m_idx} + 1'b1;
        if (m_state == 2) begin
            m_state = 0;
        end else if (m_state == 1) begin
            if (abort) begin
                evq.delete();
                push(cyc + 1, 1, 0, 3'd1, 16'h0008, 0);
                m_state = 2;
            end else if (first_now) begin
                gen_block(cyc, '0);
            end else if (ack_now) begin
                if (nx < num_steps && int'(nx) < NSTEPS) begin
                    m_idx = nx[IW-1:0];
                    gen_block(cyc, m_idx);
                end else if (loop_en) begin
                    m_idx = '0;
                    gen_block(cyc, '0);
                end else begin
                    push(cyc + 1, 0, 1, 3'd0, 16'h0, 3);
                    m_state = 0;
                end
            end
        end else if (start && num_steps >= 1 && int'(num_steps) <= NSTEPS) begin
            m_state = 1;
            m_idx = '0;
            push(cyc + 1, 1, 0, 3'd1, 16'h0008, 1);
        end
        first_now = 0;
        ack_now = 0;
        if (tbl_we) tbl_m[tbl_addr] = tbl_wdata;
    endtask

    task automatic check_cycle();
        ev_t e;
        bit have, e_cs, e_wr;
        logic [27:0] act, exp;
        have = 0;
        e = '{cyc: 0, cs: 0, wn: 1, a: 3'd0, d: 16'h0, kind: 0};
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            e = evq.pop_front();
            have = 1;
        end
        if (have && e.kind == 1) first_now = 1;
        if (have && e.kind == 2) ack_now = 1;
        if (have && e.kind == 4) begin m_state = 2; exp_err = 1; end
        e_cs = have && e.cs;
        e_wr = e_cs && !e.wn;
        exp = {e_cs, e_cs ? e.wn : 1'b1, e_cs ? e.a : 3'd0, e_wr ? e.d : 16'h0,
               have && e.kind == 2, have && e.kind == 3, m_state != 0, exp_err, m_idx};
        act = {m_chipselect, m_write_n, e_cs ? m_address : 3'd0, e_wr ? m_writedata : 16'h0,
               step_pulse, done, busy, err, step_idx};
        chk("cycle", 64'(act), 64'(exp));

        // timer slave model
        m_readdata = rd_pend ? rd_val : 16'h0;
        timer_irq = t_armed && (cyc >= t_fire);
        rd_pend = 0;
        if (m_chipselect && !m_write_n) begin
            n_wr++;
            case (m_address)
                3'd0: t_armed = 0;
                3'd1: begin
                    if (m_writedata[2]) begin
                        t_armed = 1;
                        t_fire = cyc + int'({t_ph, t_pl}) + 1;
                        last_startw = cyc;
                        n_startw++;
                    end else if (m_writedata[3]) begin
                        t_armed = 0;
                    end
                    if (m_writedata == 16'h0008) n_stopw++;
                end
                3'd2: begin t_pl = m_writedata; pl_hist.push_back(m_writedata); end
                3'd3: begin t_ph = m_writedata; ph_hist.push_back(m_writedata); end
                default: ;
            endcase
        end else if (m_chipselect) begin
            rd_pend = 1;
            rd_val = (m_address == 3'd2) ? t_pl : t_ph;
            if (m_address == 3'd2 && t_corrupt) begin
                rd_val = ~t_pl;
                t_corrupt = 0;
            end
        end
        if (step_pulse) begin last_pulse = cyc; idx_hist.push_back(int'(step_idx)); end
        if (done) begin last_done = cyc; n_done++; end
    endtask

    task automatic tick();
        model_eoc();
        @(posedge clk);
        #1;
        cyc++;
        start = 0; abort = 0; tbl_we = 0;
        check_cycle();
        if (bad > 30) finish_run();
    endtask

    task automatic twr(input int a, input logic [31:0] v);
        tbl_we = 1; tbl_addr = IW'(a); tbl_wdata = v;
        tick();
    endtask

    initial begin
        int s, d0, w0, sw0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", m_chipselect, 0);
        chk("rst_wn", m_write_n, 1);
        chk("rst_addr", m_address, 0);
        chk("rst_wdata", m_writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulse", step_pulse, 0);
        chk("rst_idx", step_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset_n = 1;
        repeat (20) tick();
        chk("idle_no_access", n_wr, 0);
        for (int i = 0; i < NSTEPS; i++) twr(i, 32'($urandom_range(1, 30)));

        // single entry of 10
        twr(0, 32'h0000_000A);
        num_steps = 1; loop_en = 0; d0 = n_done;
        s = cyc; start = 1; tick();
        for (int i = 0; i < 100 && n_done == d0; i++) tick();
        chk("t1_done_seen", n_done, d0 + 1);
        chk("t1_pl", pl_hist[pl_hist.size()-1], 16'h000A);
        chk("t1_ph", ph_hist[ph_hist.size()-1], 16'h0000);
`ifdef TIMER_SEQ_VERIFY_EN
        chk("t1_startw", last_startw - s, 8);
        chk("t1_err_clean", err, 0);
`else
        chk("t1_startw", last_startw - s, 5);
        chk("t1_pulse_vs_start", last_pulse - s, 17);
`endif
        chk("t1_pulse_vs_startw", last_pulse - last_startw, 12);
        chk("t1_done_after_pulse", last_done - last_pulse, 1);
        tick();
        chk("t1_busy_low", busy, 0);

        // looping 5,0,20 with a start while busy, then abort in WAIT_IRQ
        twr(0, 32'd5); twr(1, 32'd0); twr(2, 32'd20);
        num_steps = 3; loop_en = 1;
        pl_hist.delete(); idx_hist.delete(); d0 = n_done;
        start = 1; tick();
        repeat (10) tick();
        start = 1; tick();
        for (int i = 0; i < 400 && idx_hist.size() < 5; i++) tick();
        chk("t2_idx_count", idx_hist.size(), 5);
        if (idx_hist.size() >= 5)
            chk("t2_idx_seq", {4'(idx_hist[0]), 4'(idx_hist[1]), 4'(idx_hist[2]),
                               4'(idx_hist[3]), 4'(idx_hist[4])}, 20'h01201);
        chk("t2_zero_subst", pl_hist[1], 16'h0001);
        chk("t2_entry2", pl_hist[2], 16'd20);
        sw0 = n_startw;
        for (int i = 0; i < 20 && n_startw == sw0; i++) tick();
        tick(); tick();
        sw0 = n_stopw;
        abort = 1; tick();
        tick(); tick();
        chk("t2_abort_write", n_stopw, sw0 + 1);
        chk("t2_no_done", n_done, d0);
        chk("t2_idle", busy, 0);

        // bad num_steps ignored
        w0 = n_wr;
        num_steps = 0; start = 1; tick();
        repeat (3) tick();
        num_steps = 9; start = 1; tick();
        repeat (3) tick();
        chk("t3_no_access", n_wr, w0);
        chk("t3_busy", busy, 0);

        // rewrite entry 1 while entry 0 runs
        twr(0, 32'd8); twr(1, 32'd3);
        num_steps = 2; loop_en = 0; pl_hist.delete(); ph_hist.delete();
        start = 1; tick();
        repeat (4) tick();
        twr(1, 32'h0001_0000);
        for (int i = 0; i < 100 && ph_hist.size() < 2; i++) tick();
        chk("t4_ph_count", ph_hist.size(), 2);
        chk("t4_pl", pl_hist[pl_hist.size()-1], 16'h0000);
        chk("t4_ph", ph_hist[ph_hist.size()-1], 16'h0001);
        abort = 1; tick();
        repeat (3) tick();

        // randomized traffic against the model
        num_steps = 3; loop_en = 1;
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 24) == 0);
            abort = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) begin
                tbl_we = 1;
                tbl_addr = IW'($urandom_range(0, NSTEPS - 1));
                tbl_wdata = 32'($urandom_range(0, 30));
            end
            if ($urandom_range(0, 59) == 0) num_steps = (IW+1)'($urandom_range(0, 10));
            if ($urandom_range(0, 79) == 0) loop_en = 1'($urandom_range(0, 1));
            tick();
        end
        abort = 1; tick();
        repeat (4) tick();

`ifdef TIMER_SEQ_VERIFY_EN
        // corrupted period_l readback
        twr(0, 32'd7);
        num_steps = 1; loop_en = 0;
        t_corrupt = 1; m_corrupt = 1;
        start = 1; tick();
        repeat (20) tick();
        chk("vfy_err_set", err, 1);
        chk("vfy_idle", busy, 0);
`endif
        chk("end_queue_empty", evq.size(), 0);
        finish_run();
    end
endmodule
